bcd_score_display: RTL and testbench
====================================

Name: bcd_score_display

Overview:
- Parametrised successor to the six-digit score counter: an N-digit BCD score counter with a high-score register, overflow handling and seven-segment drive.
- Sits between the game FSM (pass/lose/cycle) and the HEX displays.
- Carry ripples through all digits in a single cycle, replacing the one-digit-per-tick carry chain.
- Adds a lose/restart state machine, a high-score latch and leading-zero blanking.

Parameters:
- DIGITS, 6, number of BCD digits (1..8).
- SATURATE, 1, 1 = hold at all-9s on overflow; 0 = wrap to 0.
- BLANK_LEADING, 1, 1 = blank leading zero digits; digit 0 is always shown.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cycle  input  1  game-tick enable; pass is sampled only when cycle=1.
- pass  input  1  score one point (qualified by cycle).
- lose  input  1  game over; sampled every clk edge, not gated by cycle.
- restart  input  1  synchronous: clear score and return to RUN.
- show_hi  input  1  1 = display high score, 0 = display current score.
- score_bcd  output  4*DIGITS  current score, packed BCD, digit 0 at [3:0].
- hi_bcd  output  4*DIGITS  high score, packed BCD.
- hex  output  7*DIGITS  active-low segments, digit i at [7i+6:7i].
- new_high  output  1  set when the last game beat the high score.
- overflow  output  1  sticky; set when an increment passed all-9s.
- lost  output  1  1 while in LOST state.

Behaviour:
- Reset (reset=0, async):
  - state=RUN; score_bcd=0, hi_bcd=0, new_high=0, overflow=0, lost=0.
  - hex shows "0" on digit 0 (7'b1000000). Other digits are blank (7'b1111111) if BLANK_LEADING, else "0".
- Release: reset deasserts asynchronously; the first active edge after release is an ordinary RUN cycle.
- States: RUN, LOST. Priority each edge: restart > lose > increment.
- RUN:
  - On an edge with cycle=1, pass=1, lose=0, restart=0: score <= score+1 in BCD.
  - Every digit that is 9 with all lower digits 9 rolls to 0 and carries; the full carry resolves within that edge.
  - Latency: score_bcd updates on the same edge; hex follows combinationally.
  - pass with cycle=0 is ignored; no edge-detect on pass, so the bench pulses it for one cycle-qualified edge.
- Overflow (score all-9s and an increment):
  - SATURATE=1: score holds at all-9s, overflow <= 1.
  - SATURATE=0: score <= 0, overflow <= 1.
  - overflow stays set until restart or reset.
- RUN, lose=1, restart=0 -> LOST on that edge:
  - No increment that edge, even if cycle and pass are both set.
  - If score > hi_bcd (packed-nibble unsigned compare, strict >): hi_bcd <= score, new_high <= 1. Otherwise hi_bcd and new_high are unchanged (new_high is already 0 in RUN).
  - lost <= 1.
- LOST:
  - score, hi_bcd, new_high and overflow are frozen; pass, cycle and lose are ignored.
  - restart=1 -> RUN: score <= 0, overflow <= 0, new_high <= 0, lost <= 0. hi_bcd is retained.
- RUN with restart=1: score, overflow and new_high clear; hi_bcd unchanged; lose and pass that edge are ignored.
- Display:
  - Source = show_hi ? hi_bcd : score_bcd (combinational; no state effect).
  - Decode per digit, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Non-BCD nibble (unreachable) = 1111111.
  - BLANK_LEADING=1: digit i>0 is blanked when it and every higher digit of the source are 0.
- Width rules: all arithmetic per-nibble; no binary conversion.

Test Plan:
- Count/carry, DIGITS=6: reset; 10 edges with cycle=1, pass=1 -> score_bcd=0x000010, hex[6:0]=1000000, hex[13:7]=1111001, hex[41:14] all 1111111. Continue to 999 then one more -> 0x001000 on that single edge.
- Gating: pass=1 with cycle=0 for 5 edges -> score unchanged. Reset asserted mid-count (async, between edges) -> score_bcd=0 immediately, without waiting for an edge.
- Lose/high score: score 0x000042 -> lose with cycle=1, pass=1 same edge -> score stays 0x000042, hi_bcd=0x000042, new_high=1, lost=1. 3 further pass pulses -> no change.
- Restart/no new high: restart -> score 0, hi 0x000042, new_high 0. Score to 0x000017, lose -> hi stays 0x000042, new_high=0. restart and lose asserted together in RUN -> state RUN, score 0.
- Overflow: DIGITS=2. SATURATE=1: 100 increments -> score 0x99, overflow=1. SATURATE=0: same stimulus -> score 0x00, overflow=1. restart -> overflow 0.
- Display mux/blanking: hi=0x000042, score=0x000007, show_hi=1 -> hex digit1=0011001, digit0=0100100. show_hi=0 -> digit0=1111000, digit1..5=1111111. With BLANK_LEADING=0, digits 1..5=1000000.

Source files
------------

// File: rtl/bcd_score_display.sv
// rtl/bcd_score_display.sv - N-digit BCD score counter with high-score latch, lose/restart FSM and 7-seg drive
module bcd_score_display #(
  parameter int DIGITS        = 6,
  parameter int SATURATE      = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cycle,
  input  logic                pass,
  input  logic                lose,
  input  logic                restart,
  input  logic                show_hi,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] hi_bcd,
  output logic [7*DIGITS-1:0] hex,
  output logic                new_high,
  output logic                overflow,
  output logic                lost
);

  localparam int W = 4 * DIGITS;

  typedef enum logic {RUN, LOST} state_t;
  state_t state;

  logic [W-1:0] inc_val;
  logic         inc_carry;
  logic [W-1:0] src;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Full ripple carry in one cycle; inc_carry high means the score was all-9s.
  always_comb begin
    logic c;
    c       = 1'b1;
    inc_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (c && score_bcd[4*i +: 4] == 4'd9) begin
        inc_val[4*i +: 4] = 4'd0;
      end else if (c) begin
        inc_val[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
        c = 1'b0;
      end else begin
        inc_val[4*i +: 4] = score_bcd[4*i +: 4];
      end
    end
    inc_carry = c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      score_bcd <= '0;
      hi_bcd    <= '0;
      new_high  <= 1'b0;
      overflow  <= 1'b0;
      lost      <= 1'b0;
    end else if (restart) begin
      state     <= RUN;
      score_bcd <= '0;
      new_high  <= 1'b0;
      overflow  <= 1'b0;
      lost      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (lose) begin
            state <= LOST;
            lost  <= 1'b1;
            if (score_bcd > hi_bcd) begin
              hi_bcd   <= score_bcd;
              new_high <= 1'b1;
            end
          end else if (cycle && pass) begin
            if (inc_carry) begin
              overflow  <= 1'b1;
              score_bcd <= (SATURATE != 0) ? score_bcd : inc_val;
            end else begin
              score_bcd <= inc_val;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign src = show_hi ? hi_bcd : score_bcd;

  // Walk from the top digit down so "all higher digits zero" is known per digit.
  always_comb begin
    logic       hz;
    logic [3:0] nib;
    hz  = 1'b1;
    nib = 4'd0;
    hex = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = src[4*i +: 4];
      if (BLANK_LEADING != 0 && i > 0 && hz && nib == 4'd0)
        hex[7*i +: 7] = 7'b1111111;
      else
        hex[7*i +: 7] = seg7(nib);
      if (nib != 4'd0) hz = 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_score_display.sv
// tb/tb_bcd_score_display.sv - directed, table-driven bench for bcd_score_display
module tb_bcd_score_display;

  logic clk = 1'b0;
  logic reset, cycle, pass, lose, restart, show_hi;

  logic [23:0] a_score, a_hi, b_score, b_hi;
  logic [41:0] a_hex, b_hex;
  logic        a_nh, a_ov, a_lost, b_nh, b_ov, b_lost;
  logic [7:0]  s_score, s_hi, w_score, w_hi;
  logic [13:0] s_hex, w_hex;
  logic        s_nh, s_ov, s_lost, w_nh, w_ov, w_lost;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_score_display #(.DIGITS(6), .SATURATE(1), .BLANK_LEADING(1)) u_a (
    .clk(clk), .reset(reset), .cycle(cycle), .pass(pass), .lose(lose), .restart(restart),
    .show_hi(show_hi), .score_bcd(a_score), .hi_bcd(a_hi), .hex(a_hex), .new_high(a_nh),
    .overflow(a_ov), .lost(a_lost));

  bcd_score_display #(.DIGITS(6), .SATURATE(1), .BLANK_LEADING(0)) u_b (
    .clk(clk), .reset(reset), .cycle(cycle), .pass(pass), .lose(lose), .restart(restart),
    .show_hi(show_hi), .score_bcd(b_score), .hi_bcd(b_hi), .hex(b_hex), .new_high(b_nh),
    .overflow(b_ov), .lost(b_lost));

  bcd_score_display #(.DIGITS(2), .SATURATE(1), .BLANK_LEADING(1)) u_s (
    .clk(clk), .reset(reset), .cycle(cycle), .pass(pass), .lose(lose), .restart(restart),
    .show_hi(show_hi), .score_bcd(s_score), .hi_bcd(s_hi), .hex(s_hex), .new_high(s_nh),
    .overflow(s_ov), .lost(s_lost));

  bcd_score_display #(.DIGITS(2), .SATURATE(0), .BLANK_LEADING(1)) u_w (
    .clk(clk), .reset(reset), .cycle(cycle), .pass(pass), .lose(lose), .restart(restart),
    .show_hi(show_hi), .score_bcd(w_score), .hi_bcd(w_hi), .hex(w_hex), .new_high(w_nh),
    .overflow(w_ov), .lost(w_lost));

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001, S7 = 7'b1111000, SB = 7'b1111111;

  typedef struct {
    int          reps;
    logic        cyc, pas, los, rst, shi;
    logic [23:0] exp_score, exp_hi;
    logic        exp_nh, exp_lost;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic p, input logic l, input logic r, input logic s);
    cycle = c; pass = p; lose = l; restart = r; show_hi = s;
  endtask

  task automatic edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input int idx);
    drive(vecs[idx].cyc, vecs[idx].pas, vecs[idx].los, vecs[idx].rst, vecs[idx].shi);
    edges(vecs[idx].reps);
    chk($sformatf("vec%0d score", idx), 64'(a_score), 64'(vecs[idx].exp_score));
    chk($sformatf("vec%0d hi", idx), 64'(a_hi), 64'(vecs[idx].exp_hi));
    chk($sformatf("vec%0d new_high", idx), 64'(a_nh), 64'(vecs[idx].exp_nh));
    chk($sformatf("vec%0d lost", idx), 64'(a_lost), 64'(vecs[idx].exp_lost));
  endtask

  initial begin
    //          reps cyc pas los rst shi score      hi         nh    lost
    vecs[0]  = '{42, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000042, 24'h000000, 1'b0, 1'b0};
    vecs[1]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000042, 24'h000042, 1'b1, 1'b1};
    vecs[2]  = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000042, 24'h000042, 1'b1, 1'b1};
    vecs[3]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000042, 24'h000042, 1'b1, 1'b1};
    vecs[4]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000042, 1'b0, 1'b0};
    vecs[5]  = '{7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000007, 24'h000042, 1'b0, 1'b0};
    vecs[6]  = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000017, 24'h000042, 1'b0, 1'b0};
    vecs[7]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000017, 24'h000042, 1'b0, 1'b1};
    vecs[8]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000042, 1'b0, 1'b0};
    vecs[9]  = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000003, 24'h000042, 1'b0, 1'b0};
    vecs[10] = '{1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000042, 1'b0, 1'b0};
    vecs[11] = '{42, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000042, 24'h000042, 1'b0, 1'b0};
    vecs[12] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000042, 24'h000042, 1'b0, 1'b1};
    vecs[13] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000042, 1'b0, 1'b0};

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    edges(2);
    chk("reset score", 64'(a_score), 64'h0);
    chk("reset hi", 64'(a_hi), 64'h0);
    chk("reset flags", 64'({a_nh, a_ov, a_lost}), 64'h0);
    chk("reset hex blank", 64'(a_hex), 64'({SB, SB, SB, SB, SB, S0}));
    chk("reset hex noblank", 64'(b_hex), 64'({S0, S0, S0, S0, S0, S0}));

    reset = 1'b1;
    #2;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(10);
    chk("count10 score", 64'(a_score), 64'h10);
    chk("count10 hex", 64'(a_hex), 64'({SB, SB, SB, SB, S1, S0}));
    edges(89);
    chk("99 sat score", 64'(s_score), 64'h99);
    chk("99 wrap score", 64'(w_score), 64'h99);
    chk("99 wrap ov", 64'(w_ov), 64'h0);
    edges(1);
    chk("100 score6", 64'(a_score), 64'h100);
    chk("100 ov6", 64'(a_ov), 64'h0);
    chk("ovf sat score", 64'(s_score), 64'h99);
    chk("ovf sat ov", 64'(s_ov), 64'h1);
    chk("ovf wrap score", 64'(w_score), 64'h00);
    chk("ovf wrap ov", 64'(w_ov), 64'h1);
    edges(3);
    chk("sat hold", 64'(s_score), 64'h99);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    edges(1);
    chk("restart ov sat", 64'(s_ov), 64'h0);
    chk("restart ov wrap", 64'(w_ov), 64'h0);
    chk("restart score", 64'(a_score), 64'h0);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(999);
    chk("count999", 64'(a_score), 64'h999);
    edges(1);
    chk("carry 999->1000", 64'(a_score), 64'h1000);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(5);
    chk("gated pass", 64'(a_score), 64'h1000);

    reset = 1'b0;
    #2;
    chk("async reset", 64'(a_score), 64'h0);
    edges(1);
    reset = 1'b1;
    #2;

    for (int i = 0; i <= 5; i++) run_vec(i);

    show_hi = 1'b1;
    #1;
    chk("hi disp blank", 64'(a_hex), 64'({SB, SB, SB, SB, S4, S2}));
    chk("hi disp noblank", 64'(b_hex), 64'({S0, S0, S0, S0, S4, S2}));
    show_hi = 1'b0;
    #1;
    chk("score disp blank", 64'(a_hex), 64'({SB, SB, SB, SB, SB, S7}));
    chk("score disp noblank", 64'(b_hex), 64'({S0, S0, S0, S0, S0, S7}));

    for (int i = 6; i < 14; i++) run_vec(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 500000 time units");
    $fatal(1);
  end

endmodule
